// File: rtl/spi_apb_bridge.sv
// SPI (mode 0) slave to APB master bridge.
// Bytes alternate command/data while CS_N is low. A command byte carries
// write/read in bit7 and the APB address in bits4:0. Writes are issued after
// the data byte; reads are issued right after the command byte, and the
// returned PRDATA is shifted out on MISO during the following data byte.
module spi_apb_bridge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       PCLK,
  input  logic       PRESET,
  input  logic       SCK,
  input  logic       CS_N,
  input  logic       MOSI,
  output logic       MISO,
  output logic       MISO_OE,
  output logic       PSEL,
  output logic       PENABLE,
  output logic       PWRITE,
  output logic [4:0] PADDR,
  output logic [7:0] PWDATA,
  input  logic [7:0] PRDATA,
  input  logic       PREADY,
  output logic       BUSY,
  output logic       OVERRUN
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  apb_state_t state, state_next;

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sck_s, cs_s, mosi_s, sck_q;
  logic                   sck_rise, sck_fall;

  logic [2:0] bit_cnt;
  logic       data_phase;
  logic [6:0] rx_sr;
  logic [7:0] rx_byte;
  logic [7:0] tx_sr;
  logic       cmd_write;
  logic [4:0] cmd_addr;
  logic       rd_wait;

  logic       byte_done;
  logic       req, req_write;
  logic [4:0] req_addr;
  logic [7:0] req_data;
  logic       accept, drop;
  logic       xfer_done, late_read, capture;

  // Synchronize the SPI pins into PCLK and keep the previous SCK for edge detection
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      sck_sync  <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sck_q     <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], SCK};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], CS_N};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      sck_q     <= sck_sync[SYNC_STAGES-1];
    end
  end

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign sck_rise = ~cs_s & sck_s & ~sck_q;
  assign sck_fall = ~cs_s & ~sck_s & sck_q;

  // Byte assembly and transfer requests; a read fires after its command
  // byte, a write only once its data byte is complete.
  assign rx_byte   = {rx_sr, mosi_s};
  assign byte_done = sck_rise && (bit_cnt == 3'd7);
  assign req       = byte_done && (data_phase ? cmd_write : ~rx_byte[7]);
  assign req_write = data_phase;
  assign req_addr  = data_phase ? cmd_addr : rx_byte[4:0];
  assign req_data  = data_phase ? rx_byte : 8'h00;
  assign accept    = req && (state == IDLE);
  assign drop      = req && (state != IDLE);
  assign xfer_done = (state == ACCESS) && PREADY;

  // A read still outstanding at the first bit of its data byte is too late:
  // the byte goes out as zeros and the returning data is thrown away.
  assign late_read = sck_rise && data_phase && (bit_cnt == 3'd0) && ~cmd_write && rd_wait;
  assign capture   = xfer_done && ~PWRITE && rd_wait && ~late_read;

  // Bit counter, command/data phase, TX shifting and read-data capture
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      bit_cnt    <= 3'd0;
      data_phase <= 1'b0;
      rx_sr      <= 7'd0;
      tx_sr      <= 8'h00;
      cmd_write  <= 1'b0;
      cmd_addr   <= 5'd0;
      rd_wait    <= 1'b0;
    end else if (cs_s) begin
      bit_cnt    <= 3'd0;
      data_phase <= 1'b0;
      tx_sr      <= 8'h00;
      rd_wait    <= 1'b0;
    end else begin
      if (sck_rise) begin
        rx_sr   <= rx_byte[6:0];
        bit_cnt <= bit_cnt + 3'd1;
        if (byte_done) begin
          data_phase <= ~data_phase;
          tx_sr      <= 8'h00;
          if (!data_phase) begin
            cmd_write <= rx_byte[7];
            cmd_addr  <= rx_byte[4:0];
          end
        end
      end else if (sck_fall && (bit_cnt != 3'd0)) begin
        // The fall that closes a byte must not shift: the next byte's MSB
        // is already on MISO at that point.
        tx_sr <= {tx_sr[6:0], 1'b0};
      end
      if (accept && !req_write) begin
        rd_wait <= 1'b1;
      end else if (late_read || (xfer_done && !PWRITE)) begin
        rd_wait <= 1'b0;
      end
      if (capture) begin
        tx_sr <= PRDATA;
      end
    end
  end

  // APB state register
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // APB next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req) state_next = SETUP;
      SETUP:   state_next = ACCESS;
      ACCESS:  if (PREADY) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Address/data latched when a transfer is accepted, held through ACCESS
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      PADDR   <= 5'd0;
      PWRITE  <= 1'b0;
      PWDATA  <= 8'h00;
      OVERRUN <= 1'b0;
    end else begin
      if (accept) begin
        PADDR  <= req_addr;
        PWRITE <= req_write;
        PWDATA <= req_data;
      end
      OVERRUN <= drop | late_read;
    end
  end

  assign PSEL    = (state == SETUP) || (state == ACCESS);
  assign PENABLE = (state == ACCESS);
  assign BUSY    = PSEL;
  assign MISO    = tx_sr[7];
  assign MISO_OE = ~cs_s;

endmodule

// File: tb/tb_spi_apb_bridge.sv
// Directed bench for spi_apb_bridge: drives SPI frames, answers APB with a
// configurable number of wait states, and checks the bus and MISO bytes
// against a transaction-level model of the frame rules.
module tb_spi_apb_bridge;
  localparam int HALF = 6;

  logic       PCLK = 1'b0;
  logic       PRESET, SCK, CS_N, MOSI;
  logic       MISO, MISO_OE, PSEL, PENABLE, PWRITE, BUSY, OVERRUN;
  logic [4:0] PADDR;
  logic [7:0] PWDATA, PRDATA;
  logic       PREADY;

  spi_apb_bridge #(.SYNC_STAGES(2)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .SCK(SCK), .CS_N(CS_N), .MOSI(MOSI),
    .MISO(MISO), .MISO_OE(MISO_OE), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .BUSY(BUSY), .OVERRUN(OVERRUN)
  );

  always #5 PCLK = ~PCLK;

  typedef struct packed {
    logic [4:0] addr;
    logic       wr;
    logic [7:0] data;
  } xfer_t;

  xfer_t      exp_q[$];
  xfer_t      snap, last_x;
  int         n_chk, n_fail;
  int         wait_cycles, acc_cnt, ov_cnt, n_done;
  int         cur_psel, cur_pen, last_psel, last_pen;
  logic [7:0] fb[8];
  logic [7:0] got[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // APB completer plus per-cycle bus checks against the expected transfer queue
  task automatic monitor();
    xfer_t e;
    forever begin
      @(negedge PCLK);
      if (PSEL && PENABLE) begin
        acc_cnt++;
        PREADY = (acc_cnt > wait_cycles);
      end else begin
        acc_cnt = 0;
        PREADY = 1'b0;
      end
      if (!PRESET) begin
        chk("busy_vs_psel", 32'(BUSY), 32'(PSEL));
        if (OVERRUN) ov_cnt++;
        if (PSEL && !PENABLE) begin
          snap     = {PADDR, PWRITE, PWDATA};
          cur_psel = 1;
          cur_pen  = 0;
        end else if (PSEL && PENABLE) begin
          cur_psel++;
          cur_pen++;
          chk("apb_stable", 32'({PADDR, PWRITE, PWDATA}), 32'(snap));
          if (PREADY) begin
            last_psel = cur_psel;
            last_pen  = cur_pen;
            last_x    = snap;
            n_done++;
            if (exp_q.size() == 0) begin
              n_chk++;
              n_fail++;
              $display("FAIL apb_unexpected: got addr 0x%0h write %0d, expected no transfer", PADDR, PWRITE);
            end else begin
              e = exp_q.pop_front();
              chk("apb_addr", 32'(PADDR), 32'(e.addr));
              chk("apb_write", 32'(PWRITE), 32'(e.wr));
              if (e.wr) chk("apb_wdata", 32'(PWDATA), 32'(e.data));
            end
          end
        end else begin
          chk("penable_without_psel", 32'(PENABLE), 32'd0);
        end
      end
    end
  endtask

  // Sends fb[0..nbytes-1]; the last byte is cut to last_bits bits.
  // late=1 marks a read whose data is expected to miss its data byte.
  task automatic spi_frame(input int nbytes, input int last_bits, input logic late);
    logic [7:0] r, e;
    int         bits;
    bit         full_next;
    for (int i = 0; i < nbytes; i += 2) begin
      if (i == nbytes - 1 && last_bits < 8) break;
      full_next = (i + 1 < nbytes) && !(i + 1 == nbytes - 1 && last_bits < 8);
      if (!fb[i][7]) exp_q.push_back({fb[i][4:0], 1'b0, 8'h00});
      else if (full_next) exp_q.push_back({fb[i][4:0], 1'b1, fb[i+1]});
    end
    @(negedge PCLK);
    CS_N = 1'b0;
    repeat (HALF) @(negedge PCLK);
    chk("miso_oe_active", 32'(MISO_OE), 32'd1);
    for (int i = 0; i < nbytes; i++) begin
      bits = (i == nbytes - 1) ? last_bits : 8;
      r = 8'h00;
      for (int j = 0; j < bits; j++) begin
        MOSI = fb[i][7-j];
        repeat (HALF) @(negedge PCLK);
        r = {r[6:0], MISO};
        SCK = 1'b1;
        repeat (HALF) @(negedge PCLK);
        SCK = 1'b0;
      end
      got[i] = r;
      if (bits == 8) begin
        e = 8'h00;
        if ((i % 2 == 1) && !fb[i-1][7] && !late) e = PRDATA;
        chk($sformatf("miso_byte%0d", i), 32'(r), 32'(e));
      end
    end
    repeat (HALF) @(negedge PCLK);
    CS_N = 1'b1;
    MOSI = 1'b0;
    repeat (HALF) @(negedge PCLK);
    chk("miso_oe_idle", 32'(MISO_OE), 32'd0);
    chk("miso_idle", 32'(MISO), 32'd0);
  endtask

  task automatic wait_idle(input int exp_left);
    int k;
    k = 0;
    while (BUSY && k < 3000) begin
      @(negedge PCLK);
      k++;
    end
    chk("busy_settled", 32'(BUSY), 32'd0);
    repeat (2) @(negedge PCLK);
    chk("pending_xfers", 32'(exp_q.size()), 32'(exp_left));
    exp_q.delete();
  endtask

  initial begin
    int k, n0, ov0;
    n_chk = 0; n_fail = 0; wait_cycles = 0; acc_cnt = 0; ov_cnt = 0; n_done = 0;
    cur_psel = 0; cur_pen = 0; last_psel = 0; last_pen = 0;
    snap = '0; last_x = '0;
    PRESET = 1'b1; SCK = 1'b0; CS_N = 1'b1; MOSI = 1'b0; PRDATA = 8'h00; PREADY = 1'b0;
    fork
      monitor();
    join_none
    repeat (3) @(negedge PCLK);
    chk("reset_outputs", 32'({PSEL, PENABLE, PWRITE, PADDR, PWDATA, MISO, MISO_OE, BUSY, OVERRUN}), 32'd0);
    PRESET = 1'b0;
    repeat (5) @(negedge PCLK);

    // Write 0x5A to 0x03, zero wait states
    wait_cycles = 0;
    fb[0] = 8'h83; fb[1] = 8'h5A;
    spi_frame(2, 8, 1'b0);
    wait_idle(0);
    chk("w_psel_cycles", 32'(last_psel), 32'd2);
    chk("w_penable_cycles", 32'(last_pen), 32'd1);
    chk("w_addr_literal", 32'(last_x.addr), 32'h03);
    chk("w_data_literal", 32'(last_x.data), 32'h5A);
    chk("w_dir_literal", 32'(last_x.wr), 32'd1);

    // Read 0x01, PRDATA 0xC3 returned on MISO
    PRDATA = 8'hC3;
    fb[0] = 8'h01; fb[1] = 8'h00;
    spi_frame(2, 8, 1'b0);
    wait_idle(0);
    chk("r_miso_literal", 32'(got[1]), 32'hC3);
    chk("r_addr_literal", 32'(last_x.addr), 32'h01);
    chk("r_dir_literal", 32'(last_x.wr), 32'd0);

    // Read 0x02 with three wait states
    wait_cycles = 3;
    PRDATA = 8'h96;
    fb[0] = 8'h02; fb[1] = 8'h00;
    spi_frame(2, 8, 1'b0);
    wait_idle(0);
    chk("ws_penable_cycles", 32'(last_pen), 32'd4);
    chk("ws_psel_cycles", 32'(last_psel), 32'd5);
    chk("ws_miso_literal", 32'(got[1]), 32'h96);

    // Read too slow for its data byte, then a write in the same frame
    wait_cycles = 40;
    PRDATA = 8'hA5;
    ov0 = ov_cnt;
    fb[0] = 8'h03; fb[1] = 8'h00; fb[2] = 8'h85; fb[3] = 8'h22;
    spi_frame(4, 8, 1'b1);
    wait_idle(0);
    chk("late_overrun_pulses", 32'(ov_cnt - ov0), 32'd1);
    chk("late_miso_literal", 32'(got[1]), 32'h00);
    chk("late_next_addr", 32'(last_x.addr), 32'h05);
    chk("late_next_data", 32'(last_x.data), 32'h22);

    // Data byte cut after 4 bits: no write; then the full frame writes
    wait_cycles = 0;
    n0 = n_done;
    fb[0] = 8'h84; fb[1] = 8'h11;
    spi_frame(2, 4, 1'b0);
    wait_idle(0);
    chk("partial_no_write", 32'(n_done - n0), 32'd0);
    spi_frame(2, 8, 1'b0);
    wait_idle(0);
    chk("after_partial_count", 32'(n_done - n0), 32'd1);
    chk("after_partial_addr", 32'(last_x.addr), 32'h04);
    chk("after_partial_data", 32'(last_x.data), 32'h11);

    // Second write arrives while the first is still stalled: dropped
    wait_cycles = 300;
    ov0 = ov_cnt;
    fb[0] = 8'h80; fb[1] = 8'h01; fb[2] = 8'h81; fb[3] = 8'h02;
    spi_frame(4, 8, 1'b0);
    wait_idle(1);
    chk("drop_overrun_pulses", 32'(ov_cnt - ov0), 32'd1);
    chk("drop_first_data", 32'(last_x.data), 32'h01);

    // Lone command bytes: write issues nothing, read still issues
    wait_cycles = 0;
    PRDATA = 8'h3C;
    n0 = n_done;
    fb[0] = 8'h86;
    spi_frame(1, 8, 1'b0);
    wait_idle(0);
    chk("lone_write_none", 32'(n_done - n0), 32'd0);
    fb[0] = 8'h07;
    spi_frame(1, 8, 1'b0);
    wait_idle(0);
    chk("lone_read_count", 32'(n_done - n0), 32'd1);
    chk("lone_read_addr", 32'(last_x.addr), 32'h07);

    // Reset while a read is stalled in ACCESS
    wait_cycles = 1000;
    fb[0] = 8'h02;
    spi_frame(1, 8, 1'b0);
    k = 0;
    while (!PENABLE && k < 100) begin
      @(negedge PCLK);
      k++;
    end
    chk("stall_in_access", 32'(PENABLE), 32'd1);
    repeat (2) @(negedge PCLK);
    PRESET = 1'b1;
    #1;
    chk("midreset_outputs", 32'({PSEL, PENABLE, PWRITE, PADDR, PWDATA, MISO, MISO_OE, BUSY, OVERRUN}), 32'd0);
    repeat (3) @(negedge PCLK);
    PRESET = 1'b0;
    exp_q.delete();
    wait_cycles = 0;
    repeat (3) @(negedge PCLK);
    chk("post_reset_idle", 32'({PSEL, BUSY}), 32'd0);
    fb[0] = 8'h9F; fb[1] = 8'hE7;
    spi_frame(2, 8, 1'b0);
    wait_idle(0);
    chk("post_reset_addr", 32'(last_x.addr), 32'h1F);
    chk("post_reset_data", 32'(last_x.data), 32'hE7);
    chk("post_reset_penable", 32'(last_pen), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
